// File: rtl/bsg_manycore_store_credit_tracker.sv
// bsg_manycore_store_credit_tracker: per-channel outstanding remote-store credit tracker with fence, readback and sticky underflow
// Ports:
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   send_v_i / send_ready_o     per-channel store issue handshake (gated by credit limit and fence)
//   ret_v_i                     per-channel store acknowledgement, always consumed
//   fence_v_i / fence_mask_i    fence request and the channels it waits on
//   fence_ready_o               fence request accepted this cycle
//   fence_done_o                one-cycle pulse once every masked channel has drained
//   rd_chan_i / rd_data_o       combinational zero-extended count readback
//   underflow_o / clear_err_i   sticky per-channel underflow flags and their clear
module bsg_manycore_store_credit_tracker #(
    parameter int num_chan_p = 2,
    parameter int max_out_p = 16,
    parameter int data_width_p = 32,
    localparam int cntr_width_lp = $clog2(max_out_p+1),
    localparam int chan_id_width_lp = (num_chan_p == 1) ? 1 : $clog2(num_chan_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [num_chan_p-1:0]       send_v_i,
    output logic [num_chan_p-1:0]       send_ready_o,
    input  logic [num_chan_p-1:0]       ret_v_i,
    input  logic                        fence_v_i,
    input  logic [num_chan_p-1:0]       fence_mask_i,
    output logic                        fence_ready_o,
    output logic                        fence_done_o,
    input  logic [chan_id_width_lp-1:0] rd_chan_i,
    output logic [data_width_p-1:0]     rd_data_o,
    output logic [num_chan_p-1:0]       underflow_o,
    input  logic                        clear_err_i
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
    localparam logic [cntr_width_lp-1:0] max_lp = cntr_width_lp'(max_out_p);
    state_e state_r, state_n;
    logic [num_chan_p-1:0] mask_r, busy, acc;
    logic [cntr_width_lp-1:0] count_r [num_chan_p];
    logic [cntr_width_lp-1:0] cnt_pad [2**chan_id_width_lp];
    always_comb begin
        busy = '0;
        send_ready_o = '0;
        for (int c = 0; c < num_chan_p; c++) begin
            busy[c] = count_r[c] != '0;
            send_ready_o[c] = (count_r[c] < max_lp) & ~((state_r == WAIT) & mask_r[c]);
        end
    end
    assign acc = send_v_i & send_ready_o;
    // A send and an ack in the same cycle cancel, even at zero, so neither moves the count nor flags underflow.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int c = 0; c < num_chan_p; c++) count_r[c] <= '0;
            underflow_o <= '0;
        end else begin
            for (int c = 0; c < num_chan_p; c++) begin
                if (acc[c] & ~ret_v_i[c])
                    count_r[c] <= count_r[c] + 1'b1;
                else if (~acc[c] & ret_v_i[c] & busy[c])
                    count_r[c] <= count_r[c] - 1'b1;
                if (~acc[c] & ret_v_i[c] & ~busy[c])
                    underflow_o[c] <= 1'b1;
                else if (clear_err_i)
                    underflow_o[c] <= 1'b0;
            end
        end
    end
    always_comb begin
        state_n = (state_r == IDLE) ? (fence_v_i ? WAIT : IDLE)
                : (state_r == WAIT) ? ((|(mask_r & busy)) ? WAIT : DONE)
                : IDLE;
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            mask_r <= '0;
        end else begin
            state_r <= state_n;
            if ((state_r == IDLE) & fence_v_i)
                mask_r <= fence_mask_i;
            else if (state_r == DONE)
                mask_r <= '0;
        end
    end
    assign fence_ready_o = state_r == IDLE;
    assign fence_done_o = state_r == DONE;
    // Pad the count table to the full select range so unused select codes read back as zero.
    for (genvar i = 0; i < 2**chan_id_width_lp; i++) begin : g_pad
        if (i < num_chan_p) begin : g_real
            assign cnt_pad[i] = count_r[i];
        end else begin : g_zero
            assign cnt_pad[i] = '0;
        end
    end
    assign rd_data_o = data_width_p'(cnt_pad[rd_chan_i]);
`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            for (int c = 0; c < num_chan_p; c++) begin
                assert (count_r[c] <= max_lp) else $error("count overflow on channel %0d", c);
                if (ret_v_i[c] & ~acc[c] & ~busy[c])
                    $display("underflow on channel %0d", c);
            end
        end
    end
`endif
endmodule
